// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and buffers
// {pc, instr} pairs in a small FIFO that feeds decode via valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [32:0]      PC_LIMIT = 33'(IMEM_WORDS) << 2;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]        instr_q [DEPTH];
    logic [31:0]        pcs_q   [DEPTH];

    logic               pop;
    logic               push;
    logic               fetch_req;
    logic               in_range;
    logic               unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A full FIFO may still accept a fetch when its head leaves this cycle.
    assign fetch_req = (state_q == ST_FETCH) && ((count_q != FULL) || pop);
    assign in_range  = {1'b0, pc_q} < PC_LIMIT;

    // Next-state and FIFO control; redirect overrides fetch and pop.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = (count_q != '0) && id_ready;
        push     = 1'b0;

        if (redirect_valid) begin
            pop      = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pc_d     = {redirect_pc[31:2], 2'b00};
            state_d  = ST_FETCH;
        end else begin
            if (fetch_req) begin
                if (in_range) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            if (push) begin
                wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
            end
            count_d = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; a push into a full FIFO reuses the slot being popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pcs_q[i]   <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= imem_rdata;
            pcs_q[wr_ptr_q]   <= pc_q;
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = (count_q != '0);
    assign id_instr    = instr_q[rd_ptr_q];
    assign id_pc       = pcs_q[rd_ptr_q];
    assign id_pc_plus4 = id_pc + 32'd4;
    assign fetch_fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, fault,
// asynchronous reset and redirect colliding with pop/fill.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic [31:0] imem_addr,  imem_rdata;
    logic        id_valid,   fetch_fault;
    logic [31:0] id_instr,   id_pc,   id_pc_plus4;

    logic [31:0] s_imem_addr, s_imem_rdata;
    logic        s_id_valid,  s_fetch_fault;
    logic [31:0] s_id_instr,  s_id_pc, s_id_pc_plus4;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[31:2])
            30'd0:   mem_word = 32'h0022_8293;
            30'd1:   mem_word = 32'h0062_E233;
            30'd2:   mem_word = 32'h0062_73B3;
            30'd3:   mem_word = 32'h0072_C433;
            30'd4:   mem_word = 32'h4044_04B3;
            30'd5:   mem_word = 32'h00A4_84B3;
            30'd6:   mem_word = 32'h00B5_0533;
            30'd7:   mem_word = 32'h00C5_85B3;
            30'd8:   mem_word = 32'h00D6_0633;
            default: mem_word = {16'hC0DE, a[17:2]};
        endcase
    endfunction

    assign imem_rdata   = rst ? mem_word(imem_addr)   : 32'h0;
    assign s_imem_rdata = rst ? mem_word(s_imem_addr) : 32'h0;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .fetch_fault(fetch_fault)
    );

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4), .DEPTH(2)) dut_small (
        .clk(clk), .rst(rst),
        .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(s_id_valid), .id_ready(id_ready),
        .id_instr(s_id_instr), .id_pc(s_id_pc), .id_pc_plus4(s_id_pc_plus4),
        .fetch_fault(s_fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " valid"},  32'(id_valid),    32'd0);
        chk({tag, " addr"},   imem_addr,        32'h0);
        chk({tag, " instr"},  id_instr,         32'h0);
        chk({tag, " pc"},     id_pc,            32'h0);
        chk({tag, " pc4"},    id_pc_plus4,      32'h4);
        chk({tag, " fault"},  32'(fetch_fault), 32'd0);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, " valid"}, 32'(id_valid), 32'd1);
        chk({tag, " pc"},    id_pc,         pc);
        chk({tag, " instr"}, id_instr,      mem_word(pc));
        chk({tag, " pc4"},   id_pc_plus4,   pc + 32'd4);
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        #2;
        chk_reset_vals("rst0");

        // Stream from reset with decode always ready
        step();
        rst = 1'b1;
        chk("pre_first_edge valid", 32'(id_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk_head($sformatf("stream%0d", k), 32'(4 * k));
            chk($sformatf("stream%0d addr", k), imem_addr, 32'(4 * (k + 1)));
        end

        // Run off the end of a 4-word memory
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("small%0d pc", k), s_id_pc, 32'(4 * k));
            chk($sformatf("small%0d valid", k), 32'(s_id_valid), 32'd1);
        end
        step();
        chk("small_fault rise", 32'(s_fetch_fault), 32'd1);
        chk("small_fault valid", 32'(s_id_valid), 32'd0);
        chk("small_fault addr", s_imem_addr, 32'h10);
        step();
        chk("small_fault hold", 32'(s_fetch_fault), 32'd1);
        chk("small_fault novalid", 32'(s_id_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("small_redir fault", 32'(s_fetch_fault), 32'd0);
        chk("small_redir valid", 32'(s_id_valid), 32'd0);
        step();
        chk("small_restart pc", s_id_pc, 32'h0);
        chk("small_restart instr", s_id_instr, mem_word(32'h0));
        chk("small_restart valid", 32'(s_id_valid), 32'd1);

        // Backpressure: fill to DEPTH and stall
        rst      = 1'b0;
        id_ready = 1'b0;
        #1;
        chk_reset_vals("rst1");
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_head($sformatf("stall%0d", k), 32'h0);
        end
        chk("stall addr", imem_addr, 32'h8);
        id_ready = 1'b1;
        step();
        chk_head("drain0", 32'h4);
        chk("drain0 addr", imem_addr, 32'hC);
        step();
        chk_head("drain1", 32'h8);
        step();
        chk_head("drain2", 32'hC);

        // Redirect with two entries buffered
        id_ready = 1'b0;
        step();
        step();
        chk("full valid", 32'(id_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0012;
        step();
        redirect_valid = 1'b0;
        chk("redir valid", 32'(id_valid), 32'd0);
        chk("redir addr", imem_addr, 32'h10);
        step();
        chk_head("redir target", 32'h10);
        chk("redir word", id_instr, 32'h4044_04B3);

        // Asynchronous reset while full
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        rst      = 1'b1;
        id_ready = 1'b1;
        step();
        chk_head("after_rst", 32'h0);
        chk("after_rst addr", imem_addr, 32'h4);

        // Redirect colliding with pop and fill at count 1
        step();
        step();
        chk_head("pre_collide", 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0020;
        step();
        redirect_valid = 1'b0;
        chk("collide valid", 32'(id_valid), 32'd0);
        chk("collide addr", imem_addr, 32'h20);
        step();
        chk_head("collide t0", 32'h20);
        step();
        chk_head("collide t1", 32'h24);

        // Redirect to an out-of-range address faults one edge later
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        chk("oor addr", imem_addr, 32'hFFFF_FFFC);
        chk("oor fault0", 32'(fetch_fault), 32'd0);
        step();
        chk("oor fault1", 32'(fetch_fault), 32'd1);
        chk("oor valid", 32'(id_valid), 32'd0);
        chk("oor addr hold", imem_addr, 32'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
